// File: rtl/usb_arb_pkg.sv
// Package: usb_arb_pkg
// Purpose: shared types and defaults for the CRC stream arbiter.
//   grant_t      - which serializer currently owns the bit-stuffer input
//   arb_state_t  - arbiter FSM states
//   TOK_BITS_DEF - default token stream length (PID + addr/endp + CRC5)
//   DATA_BITS_DEF- default data stream length (72-bit packet + CRC16)
//   CNT_W        - width of the per-stream bit counter
package usb_arb_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_TOK,
    GNT_DATA
  } grant_t;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    STREAM,
    GAP
  } arb_state_t;

  localparam int TOK_BITS_DEF  = 24;
  localparam int DATA_BITS_DEF = 88;
  localparam int CNT_W         = 8;

endpackage

// File: rtl/arb_len_checker.sv
// Module: arb_len_checker
// Purpose: counts the bits the stuffer accepts from the granted serializer
//   and compares the count against the expected packet length.
// Ports:
//   clock, reset_n - clock and async active-low reset
//   clr            - clear the counter (launch cycle)
//   inc            - a bit is accepted this cycle
//   done           - granted serializer flags its last bit this cycle
//   len            - expected length of the granted stream
//   mismatch       - done arrived on an accepted bit whose index != len
//   overrun        - the len-th bit was accepted without a done
module arb_len_checker
  import usb_arb_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             done,
  input  logic [CNT_W-1:0] len,
  output logic             mismatch,
  output logic             overrun
);

  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W:0]   cnt_plus1;
  logic [CNT_W:0]   len_ext;

  // One extra bit so the compare can never alias through a wrap.
  assign cnt_plus1 = {1'b0, bit_cnt_q} + (CNT_W+1)'(1);
  assign len_ext   = {1'b0, len};

  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (clr) begin
      bit_cnt_d = '0;
    end else if (inc) begin
      bit_cnt_d = cnt_plus1[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
    end
  end

  // The overrun fires on the accepted bit that brings the count to len,
  // so the stream is aborted before the counter could pass len.
  assign mismatch = inc & done & (cnt_plus1 != len_ext);
  assign overrun  = inc & ~done & (cnt_plus1 == len_ext);

endmodule

// File: rtl/crc_stream_arbiter.sv
// Module: crc_stream_arbiter
// Purpose: shares the bit-stuffer input between the CRC5 token serializer
//   and the CRC16 data serializer. Grants one request at a time (alternating
//   on ties), launches the serializer, muxes its bit onto the stuffer,
//   checks the stream length and forces an inter-packet gap.
// Ports:
//   clock, reset_n             - clock and async active-low reset
//   tok_req / data_req         - level requests from the protocol handler
//   tok_ack / data_ack         - accept pulses (with the start pulses)
//   tok_start / data_start     - pkt_ready pulses to the CRC blocks
//   tok_bit/tok_done,
//   data_bit/data_done         - serializer bit and last-bit strobe
//   bs_ready                   - stuffer accepts a bit this cycle
//   tok_bs_ready/data_bs_ready - bs_ready gated to the granted serializer
//   bs_bit, bs_sending         - bit to stuffer, stream active
//   busy                       - arbiter not idle
//   len_err                    - packet length mismatch pulse
module crc_stream_arbiter
  import usb_arb_pkg::*;
#(
  parameter int TOK_BITS   = TOK_BITS_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int GAP_CYCLES = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic tok_req,
  input  logic data_req,
  output logic tok_ack,
  output logic data_ack,
  output logic tok_start,
  output logic data_start,
  input  logic tok_bit,
  input  logic tok_done,
  input  logic data_bit,
  input  logic data_done,
  input  logic bs_ready,
  output logic tok_bs_ready,
  output logic data_bs_ready,
  output logic bs_bit,
  output logic bs_sending,
  output logic busy,
  output logic len_err
);

  if (TOK_BITS < 1 || TOK_BITS > 255 || DATA_BITS < 1 || DATA_BITS > 255 ||
      GAP_CYCLES < 1 || GAP_CYCLES > 256) begin : g_param_check
    $error("crc_stream_arbiter: stream lengths must be 1..255, GAP_CYCLES 1..256");
  end

  localparam logic [CNT_W-1:0] TOK_LEN  = CNT_W'(TOK_BITS);
  localparam logic [CNT_W-1:0] DATA_LEN = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  arb_state_t       state_q, state_d;
  grant_t           grant_q, grant_d;
  grant_t           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;

  logic             tok_sel, data_sel;
  logic             launching, streaming;
  logic             gnt_bit, gnt_done;
  logic [CNT_W-1:0] cur_len;
  logic             cnt_inc;
  logic             mismatch, overrun;

  assign tok_sel   = (grant_q == GNT_TOK);
  assign data_sel  = (grant_q == GNT_DATA);
  assign launching = (state_q == LAUNCH);
  assign streaming = (state_q == STREAM);

  // Only the granted serializer is listened to; the other one's done is ignored.
  assign gnt_bit  = (tok_sel & tok_bit)  | (data_sel & data_bit);
  assign gnt_done = (tok_sel & tok_done) | (data_sel & data_done);
  assign cur_len  = data_sel ? DATA_LEN : TOK_LEN;
  assign cnt_inc  = streaming & bs_ready;

  arb_len_checker u_len_checker (
    .clock    (clock),
    .reset_n  (reset_n),
    .clr      (launching),
    .inc      (cnt_inc),
    .done     (gnt_done),
    .len      (cur_len),
    .mismatch (mismatch),
    .overrun  (overrun)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    gap_cnt_d    = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (tok_req && data_req) begin
          // Tie: hand the stuffer to whoever did not get it last time.
          grant_d = (last_grant_q == GNT_TOK) ? GNT_DATA : GNT_TOK;
          state_d = LAUNCH;
        end else if (tok_req) begin
          grant_d = GNT_TOK;
          state_d = LAUNCH;
        end else if (data_req) begin
          grant_d = GNT_DATA;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        last_grant_d = grant_q;
        state_d      = STREAM;
      end
      STREAM: begin
        // Both a done and an overrun only count on an accepted bit, so a
        // stalled stuffer freezes the stream here.
        if (cnt_inc && (gnt_done || overrun)) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
          grant_d = GNT_NONE;
        end else begin
          gap_cnt_d = gap_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_DATA;
      gap_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // Outputs decode the registered state so a reset clears them at once.
  assign tok_ack       = launching & tok_sel;
  assign tok_start     = launching & tok_sel;
  assign data_ack      = launching & data_sel;
  assign data_start    = launching & data_sel;
  assign tok_bs_ready  = streaming & tok_sel & bs_ready;
  assign data_bs_ready = streaming & data_sel & bs_ready;
  assign bs_bit        = streaming & gnt_bit;
  assign bs_sending    = streaming;
  assign busy          = (state_q != IDLE);
  assign len_err       = mismatch | overrun;

endmodule
